// File: rtl/w5300_sock_rx_pkg.sv
// Shared W5300 definitions: register map, command codes and the socket-RX FSM states.
package w5300_sock_rx_pkg;

    localparam logic [9:0] SN_CR       = 10'h202;
    localparam logic [9:0] SN_IR       = 10'h206;
    localparam logic [9:0] SN_RX_RSR0  = 10'h228;
    localparam logic [9:0] SN_RX_RSR2  = 10'h22A;
    localparam logic [9:0] SN_RX_FIFOR = 10'h230;

    localparam logic [15:0] SN_CR_RECV     = 16'h0040;
    localparam logic [15:0] SN_IR_IMR_RECV = 16'h0004;

    localparam int RX_HDR_WORDS = 4;

    typedef enum logic [3:0] {
        IDLE, WAIT, RSR0, RSR2, HDR_IP0, HDR_IP2, HDR_PORT, HDR_LEN, DATA, CMD_RECV, CLR_IR
    } rx_state_t;

    // Socket register blocks are 0x40 apart; base is the socket-0 address.
    function automatic logic [9:0] get_socket_n_reg(input logic [9:0] base, input int unsigned sock);
        return base + 10'(sock * 32'h40);
    endfunction

endpackage

// File: rtl/w5300_sock_rx_poll_timer.sv
// Idle-poll interval timer: a start pulse begins a run, done pulses once CYCLES clocks later.
module poll_timer #(
    parameter int CYCLES = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    output logic done
);
    localparam int CW = $clog2(CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);

    logic [CW-1:0] cnt;
    logic          run;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                cnt <= '0;
                run <= 1'b1;
            end else if (run) begin
                if (cnt == LAST) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/w5300_sock_rx.sv
// Drains one W5300 UDP socket: polls RX_RSR, reads the 8-byte header, streams payload, acks with RECV.
module w5300_sock_rx
    import w5300_sock_rx_pkg::*;
#(
    parameter int SOCKET      = 0,
    parameter int POLL_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    output logic        bus_req,
    output logic        bus_wr,
    output logic [9:0]  bus_addr,
    output logic [15:0] bus_wdata,
    input  logic        bus_ack,
    input  logic [15:0] bus_rdata,
    output logic        hdr_valid,
    output logic [31:0] hdr_ip,
    output logic [15:0] hdr_port,
    output logic [15:0] hdr_len,
    output logic [15:0] rx_data,
    output logic        rx_valid,
    output logic        rx_last,
    output logic        rx_odd,
    input  logic        rx_ready,
    output logic        busy
);
    localparam logic [9:0] A_RSR0  = get_socket_n_reg(SN_RX_RSR0, SOCKET);
    localparam logic [9:0] A_RSR2  = get_socket_n_reg(SN_RX_RSR2, SOCKET);
    localparam logic [9:0] A_FIFOR = get_socket_n_reg(SN_RX_FIFOR, SOCKET);
    localparam logic [9:0] A_CR    = get_socket_n_reg(SN_CR, SOCKET);
    localparam logic [9:0] A_IR    = get_socket_n_reg(SN_IR, SOCKET);

    rx_state_t   state;
    logic [16:0] rsr;
    logic [15:0] words_left;
    logic        timer_done;
    logic        timer_start;

    logic        bus_state, issue, done;
    logic [9:0]  req_addr;
    logic        req_wr;
    logic [15:0] req_wdata;

    // 17-bit length math so len=0xFFFF rounds up to 0x8000 words without wrapping.
    logic [16:0] len_p1;
    logic [15:0] words;
    logic [17:0] need;
    logic        short_pkt;

    assign len_p1    = {1'b0, bus_rdata} + 17'd1;
    assign words     = len_p1[16:1];
    assign need      = 18'd8 + {1'b0, words, 1'b0};
    assign short_pkt = ({1'b0, rsr} < need);

    assign timer_start = (state == IDLE) && en;

    poll_timer #(.CYCLES(POLL_CYCLES)) u_poll_timer (
        .clk   (clk),
        .rst   (rst),
        .start (timer_start),
        .done  (timer_done)
    );

    always_comb begin
        req_addr  = A_FIFOR;
        req_wr    = 1'b0;
        req_wdata = 16'h0000;
        case (state)
            RSR0:     req_addr = A_RSR0;
            RSR2:     req_addr = A_RSR2;
            CMD_RECV: begin req_addr = A_CR; req_wr = 1'b1; req_wdata = SN_CR_RECV;     end
            CLR_IR:   begin req_addr = A_IR; req_wr = 1'b1; req_wdata = SN_IR_IMR_RECV; end
            default:  ;
        endcase
    end

    assign bus_state = (state inside {RSR0, RSR2, HDR_IP0, HDR_IP2, HDR_PORT, HDR_LEN, DATA, CMD_RECV, CLR_IR});
    // A payload read is only launched once the previous word has left the output register.
    assign issue     = bus_state && !bus_req && !(state == DATA && rx_valid);
    assign done      = bus_req && bus_ack;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            bus_req    <= 1'b0;
            bus_wr     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            hdr_valid  <= 1'b0;
            hdr_ip     <= '0;
            hdr_port   <= '0;
            hdr_len    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_last    <= 1'b0;
            rx_odd     <= 1'b0;
            busy       <= 1'b0;
            rsr        <= '0;
            words_left <= '0;
        end else begin
            hdr_valid <= 1'b0;
            if (issue) begin
                bus_req   <= 1'b1;
                bus_wr    <= req_wr;
                bus_addr  <= req_addr;
                bus_wdata <= req_wdata;
            end
            if (done) bus_req <= 1'b0;

            case (state)
                IDLE: if (en) state <= WAIT;
                WAIT: if (timer_done) begin state <= RSR0; busy <= 1'b1; end
                RSR0: if (done) begin rsr[16] <= bus_rdata[0]; state <= RSR2; end
                RSR2: if (done) begin
                    rsr[15:0] <= bus_rdata;
                    if ({rsr[16], bus_rdata} == 17'd0) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= HDR_IP0;
                    end
                end
                HDR_IP0:  if (done) begin hdr_ip[31:16] <= bus_rdata; state <= HDR_IP2;  end
                HDR_IP2:  if (done) begin hdr_ip[15:0]  <= bus_rdata; state <= HDR_PORT; end
                HDR_PORT: if (done) begin hdr_port      <= bus_rdata; state <= HDR_LEN;  end
                HDR_LEN: if (done) begin
                    hdr_len    <= bus_rdata;
                    words_left <= words;
                    if (short_pkt) begin
                        state <= CMD_RECV;
                    end else begin
                        hdr_valid <= 1'b1;
                        state     <= (words == 16'd0) ? CMD_RECV : DATA;
                    end
                end
                DATA: begin
                    if (done) begin
                        rx_data    <= bus_rdata;
                        rx_valid   <= 1'b1;
                        rx_last    <= (words_left == 16'd1);
                        rx_odd     <= (words_left == 16'd1) & hdr_len[0];
                        words_left <= words_left - 1'b1;
                    end else if (rx_valid && rx_ready) begin
                        rx_valid <= 1'b0;
                        rx_last  <= 1'b0;
                        rx_odd   <= 1'b0;
                        if (rx_last) state <= CMD_RECV;
                    end
                end
                CMD_RECV: if (done) state <= CLR_IR;
                CLR_IR:   if (done) state <= RSR0;
                default:  state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_w5300_sock_rx.sv
// Directed bench for w5300_sock_rx with a latency-2 W5300 bus model and a packet vector table.
module tb_w5300_sock_rx;
    import w5300_sock_rx_pkg::*;

    localparam int POLL = 40;
    localparam int LAT  = 2;
    localparam logic [9:0] T_RSR0 = 10'h268, T_RSR2 = 10'h26A, T_FIFOR = 10'h270,
                           T_CR = 10'h242, T_IR = 10'h246;

    logic        clk, rst, en;
    logic        bus_req, bus_wr, bus_ack;
    logic [9:0]  bus_addr;
    logic [15:0] bus_wdata, bus_rdata;
    logic        hdr_valid;
    logic [31:0] hdr_ip;
    logic [15:0] hdr_port, hdr_len, rx_data;
    logic        rx_valid, rx_last, rx_odd, rx_ready, busy;

    w5300_sock_rx #(.SOCKET(1), .POLL_CYCLES(POLL)) dut (
        .clk(clk), .rst(rst), .en(en),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .hdr_valid(hdr_valid), .hdr_ip(hdr_ip), .hdr_port(hdr_port), .hdr_len(hdr_len),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_odd(rx_odd),
        .rx_ready(rx_ready), .busy(busy)
    );

    typedef struct {
        logic [31:0]      ip;
        logic [15:0]      port;
        logic [15:0]      len;
        logic [16:0]      rsr;
        logic [2:0][15:0] data;
        int               stall_beat;
        int               stall_len;
        int               exp_hdr;
        int               exp_beats;
        logic             exp_odd;
        int               exp_stall;
    } vec_t;
    typedef struct { logic [9:0] addr; logic wr; logic [15:0] wdata; int cyc; } acc_t;
    typedef struct { logic [31:0] ip; logic [15:0] port; logic [15:0] len; } hdr_t;
    typedef struct { logic [15:0] data; logic last; logic odd; } beat_t;

    vec_t vecs[6];
    acc_t acc_log[$];
    hdr_t hdrs[$];
    beat_t beats[$];
    logic [16:0] rsr_q[$];
    logic [15:0] fifo_q[$];

    int n_vec = 0, n_err = 0, cyc = 0;
    int stall_beat = -1, stall_len = 0, stall_done = 0, stall_cycles = 0, viol = 0;
    logic stall_active = 1'b0;
    logic [15:0] held;

    initial begin clk = 1'b0; forever #5 clk = ~clk; end
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Bus model: ack LAT cycles after bus_req rises, with register/FIFO side effects.
    initial begin
        int lat;
        lat = 0; bus_ack = 1'b0; bus_rdata = 16'h0;
        forever begin
            @(posedge clk); #1;
            bus_ack = 1'b0;
            if (rst) lat = 0;
            else if (bus_req) begin
                if (lat == LAT - 1) begin
                    lat = 0;
                    bus_ack = 1'b1;
                    bus_rdata = 16'h0;
                    if (!bus_wr) begin
                        if (bus_addr == T_RSR0)
                            bus_rdata = (rsr_q.size() > 0) ? {15'd0, rsr_q[0][16]} : 16'h0;
                        else if (bus_addr == T_RSR2)
                            bus_rdata = (rsr_q.size() > 0) ? rsr_q.pop_front() : 16'h0;
                        else if (bus_addr == T_FIFOR)
                            bus_rdata = (fifo_q.size() > 0) ? fifo_q.pop_front() : 16'hDEAD;
                    end
                    acc_log.push_back('{bus_addr, bus_wr, bus_wdata, cyc});
                end else lat++;
            end
        end
    end

    // Sink backpressure: hold rx_ready low stall_len cycles on the chosen beat.
    initial begin
        rx_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rx_valid && beats.size() == stall_beat && stall_done < stall_len) begin
                rx_ready = 1'b0;
                stall_done++;
            end else rx_ready = 1'b1;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (hdr_valid) hdrs.push_back('{hdr_ip, hdr_port, hdr_len});
            if (rx_valid && rx_ready) beats.push_back('{rx_data, rx_last, rx_odd});
            if (rx_valid && !rx_ready) begin
                stall_cycles++;
                if (!stall_active) begin held = rx_data; stall_active = 1'b1; end
                else if (rx_data !== held) viol++;
            end else stall_active = 1'b0;
            if (bus_req && bus_addr == T_FIFOR && rx_valid) viol++;
        end
    end

    task automatic clear_all();
        acc_log.delete(); hdrs.delete(); beats.delete(); rsr_q.delete(); fifo_q.delete();
        stall_beat = -1; stall_len = 0; stall_done = 0; stall_cycles = 0; viol = 0;
    endtask

    task automatic load_pkt(input vec_t v);
        int nw;
        nw = (int'(v.len) + 1) / 2;
        fifo_q.push_back(v.ip[31:16]); fifo_q.push_back(v.ip[15:0]);
        fifo_q.push_back(v.port);      fifo_q.push_back(v.len);
        for (int i = 0; i < nw && i < 3; i++) fifo_q.push_back(v.data[i]);
    endtask

    task automatic kick();
        @(posedge clk); #1 en = 1'b1;
        @(posedge clk); #1 en = 1'b0;
    endtask

    task automatic wait_done();
        int i;
        i = 0;
        while (!busy && i < POLL + 100) begin @(negedge clk); i++; end
        chk("busy_rise", 32'(busy), 32'd1);
        i = 0;
        while (busy && i < 3000) begin @(negedge clk); i++; end
        chk("busy_fall", 32'(busy), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    function automatic int count_acc(input logic [9:0] a, input logic w);
        int n;
        n = 0;
        foreach (acc_log[i]) if (acc_log[i].addr == a && acc_log[i].wr == w) n++;
        return n;
    endfunction

    task automatic run_vec(input vec_t v, input int idx);
        int fl, wi;
        clear_all();
        stall_beat = v.stall_beat; stall_len = v.stall_len;
        rsr_q.push_back(v.rsr); rsr_q.push_back(17'd0);
        load_pkt(v);
        kick();
        wait_done();
        chk($sformatf("v%0d_hdr_count", idx), 32'(hdrs.size()), 32'(v.exp_hdr));
        if (hdrs.size() > 0) begin
            chk($sformatf("v%0d_hdr_ip", idx), hdrs[0].ip, v.ip);
            chk($sformatf("v%0d_hdr_port", idx), 32'(hdrs[0].port), 32'(v.port));
            chk($sformatf("v%0d_hdr_len", idx), 32'(hdrs[0].len), 32'(v.len));
        end
        chk($sformatf("v%0d_beats", idx), 32'(beats.size()), 32'(v.exp_beats));
        for (int i = 0; i < beats.size() && i < 3; i++) begin
            chk($sformatf("v%0d_b%0d_data", idx, i), 32'(beats[i].data), 32'(v.data[i]));
            chk($sformatf("v%0d_b%0d_last", idx, i), 32'(beats[i].last), 32'(i == v.exp_beats - 1));
            chk($sformatf("v%0d_b%0d_odd", idx, i), 32'(beats[i].odd),
                (i == v.exp_beats - 1) ? 32'(v.exp_odd) : 32'd0);
        end
        fl = count_acc(T_FIFOR, 1'b0);
        chk($sformatf("v%0d_fifo_reads", idx), 32'(fl), 32'(RX_HDR_WORDS + v.exp_beats));
        chk($sformatf("v%0d_cr_writes", idx), 32'(count_acc(T_CR, 1'b1)), 32'd1);
        chk($sformatf("v%0d_ir_writes", idx), 32'(count_acc(T_IR, 1'b1)), 32'd1);
        wi = -1;
        foreach (acc_log[i]) if (acc_log[i].wr && wi < 0) wi = i;
        if (wi >= 0 && wi + 1 < acc_log.size()) begin
            chk($sformatf("v%0d_cr_data", idx), 32'(acc_log[wi].wdata), 32'h0040);
            chk($sformatf("v%0d_ir_addr", idx), 32'(acc_log[wi+1].addr), 32'(T_IR));
            chk($sformatf("v%0d_ir_data", idx), 32'(acc_log[wi+1].wdata), 32'h0004);
        end else chk($sformatf("v%0d_write_seq", idx), 32'(wi), 32'hFFFF_FFFF);
        chk($sformatf("v%0d_stall_cycles", idx), 32'(stall_cycles), 32'(v.exp_stall));
        chk($sformatf("v%0d_stall_viol", idx), 32'(viol), 32'd0);
    endtask

    initial begin
        int k, i;
        vec_t p2;
        vecs[0] = '{32'hC0A8_0102, 16'h1F90, 16'd5, 17'd14, {16'h5500, 16'h3344, 16'h1122}, -1, 0, 1, 3, 1'b1, 0};
        vecs[1] = '{32'h0A00_0001, 16'h0050, 16'd4, 17'd12, {16'h0000, 16'hBBBB, 16'hAAAA},  1, 7, 1, 2, 1'b0, 7};
        vecs[2] = '{32'h0A00_0002, 16'h1234, 16'd0, 17'd8,  48'h0,                          -1, 0, 1, 0, 1'b0, 0};
        vecs[3] = '{32'h0A00_0003, 16'h4321, 16'd6, 17'd13, {16'h3333, 16'h2222, 16'h1111}, -1, 0, 0, 0, 1'b0, 0};
        vecs[4] = '{32'h0A00_0004, 16'h0007, 16'd1, 17'd10, {16'h0000, 16'h0000, 16'hAB00}, -1, 0, 1, 1, 1'b1, 0};
        vecs[5] = '{32'hFFFF_0000, 16'hFFFF, 16'd2, 17'h10000, {16'h0000, 16'h0000, 16'h1234}, -1, 0, 1, 1, 1'b0, 0};

        rst = 1'b1; en = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_hdr_valid", 32'(hdr_valid), 0);
        chk("rst_rx_valid", 32'(rx_valid), 0);
        chk("rst_state", 32'(dut.state), 32'(IDLE));

        // Empty socket: two RSR reads at the socket-1 addresses, then back to IDLE.
        clear_all();
        rsr_q.push_back(17'd0);
        kick();
        wait_done();
        chk("rsr0_count", 32'(acc_log.size()), 32'd2);
        if (acc_log.size() >= 2) begin
            chk("rsr0_addr0", 32'(acc_log[0].addr), 32'(T_RSR0));
            chk("rsr0_addr1", 32'(acc_log[1].addr), 32'(T_RSR2));
        end
        chk("rsr0_fifo", 32'(count_acc(T_FIFOR, 1'b0)), 0);
        chk("rsr0_state", 32'(dut.state), 32'(IDLE));

        for (int v = 0; v < 6; v++) run_vec(vecs[v], v);

        // Two packets queued: second one drained straight from CLR_IR.
        clear_all();
        p2 = vecs[1];
        rsr_q.push_back(17'd14); rsr_q.push_back(17'd12); rsr_q.push_back(17'd0);
        load_pkt(vecs[0]); load_pkt(p2);
        kick();
        wait_done();
        chk("two_hdrs", 32'(hdrs.size()), 32'd2);
        if (hdrs.size() == 2) chk("two_len2", 32'(hdrs[1].len), 32'd4);
        chk("two_beats", 32'(beats.size()), 32'd5);
        if (beats.size() == 5) begin
            chk("two_b4_data", 32'(beats[4].data), 32'hBBBB);
            chk("two_b4_last", 32'(beats[4].last), 32'd1);
        end
        k = -1;
        foreach (acc_log[j]) if (acc_log[j].addr == T_IR && k < 0) k = j;
        if (k >= 0 && k + 1 < acc_log.size()) begin
            chk("two_next_rsr0", 32'(acc_log[k+1].addr), 32'(T_RSR0));
            chk("two_gap_short", 32'(acc_log[k+1].cyc - acc_log[k].cyc < POLL), 32'd1);
        end else chk("two_ir_found", 32'(k), 32'hFFFF_FFFF);

        // Reset while a payload read is outstanding.
        clear_all();
        rsr_q.push_back(17'd12); rsr_q.push_back(17'd0);
        load_pkt(vecs[1]);
        kick();
        i = 0;
        while (!(dut.state == DATA && bus_req) && i < 500) begin @(negedge clk); i++; end
        chk("rstd_reached_data", 32'(dut.state == DATA && bus_req), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstd_bus_req", 32'(bus_req), 0);
        chk("rstd_busy", 32'(busy), 0);
        chk("rstd_state", 32'(dut.state), 32'(IDLE));
        chk("rstd_rx_valid", 32'(rx_valid), 0);
        @(negedge clk) rst = 1'b0;
        run_vec(vecs[0], 10);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
